// File: rtl/coproc_pkg.sv
// Shared constants, state encoding and helpers for the coprocessor matrix/scalar datapaths.
package coproc_pkg;

    localparam int unsigned ELEMS = 25;
    localparam int unsigned W     = 8;
    localparam int unsigned IdxW  = $clog2(ELEMS);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StWrite,
        StDone
    } div_state_e;

    // LSB position of element idx inside a flat matrix vector.
    function automatic int unsigned elem_lsb(input logic [IdxW-1:0] idx);
        int unsigned i;
        i = idx;
        return i * W;
    endfunction

    // Unsigned magnitude of a signed element; -128 maps to 8'h80 (=128).
    function automatic logic [W-1:0] abs_mag(input logic [W-1:0] x);
        return x[W-1] ? (~x + 1'b1) : x;
    endfunction

endpackage

// File: rtl/scalar_div_core.sv
// Serial unsigned restoring divider: one quotient bit per cycle, MSB first, 8 cycles per load.
module scalar_div_core
    import coproc_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] dividend_i,
    input  logic [W-1:0] divisor_i,
    output logic [W-1:0] quotient_o,
    output logic         valid_o
);

    logic [W-1:0] rem_q, rem_d;
    logic [W-1:0] quo_q, quo_d;
    logic [W-1:0] dsr_q, dsr_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         valid_q, valid_d;
    logic [W:0]   rem_sh;
    logic         ge;

    always_comb begin
        rem_d   = rem_q;
        quo_d   = quo_q;
        dsr_d   = dsr_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        // 9-bit partial remainder; the kept remainder is always below the divisor (<= 127).
        rem_sh  = {rem_q, quo_q[W-1]};
        ge      = rem_sh >= {1'b0, dsr_q};
        if (load_i) begin
            rem_d = '0;
            quo_d = dividend_i;
            dsr_d = divisor_i;
            cnt_d = 4'd8;
        end else if (cnt_q != 4'd0) begin
            rem_d   = ge ? (rem_sh[W-1:0] - dsr_q) : rem_sh[W-1:0];
            quo_d   = {quo_q[W-2:0], ge};
            cnt_d   = cnt_q - 4'd1;
            valid_d = (cnt_q == 4'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q   <= '0;
            quo_q   <= '0;
            dsr_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dsr_q   <= dsr_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign quotient_o = quo_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/alu_scalar_div_module.sv
// Signed 5x5 int8 matrix divided by an int8 scalar, one element at a time through a shared
// serial divider; truncates toward zero and flags -128/-1 overflow and divide-by-zero.
module alu_scalar_div_module
    import coproc_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ELEMS*W-1:0] A_flat,
    input  logic [W-1:0]       scalar,
    output logic [ELEMS*W-1:0] C_flat,
    output logic               busy,
    output logic               done,
    output logic               overflow_flag,
    output logic               div_by_zero_flag
);

    localparam logic [IdxW-1:0] LastIdx = IdxW'(ELEMS - 1);

    div_state_e         state_q, state_d;
    logic [ELEMS*W-1:0] a_q, a_d;
    logic [ELEMS*W-1:0] c_q, c_d;
    logic [W-1:0]       b_q, b_d;
    logic [IdxW-1:0]    idx_q, idx_d, idx_nxt;
    logic [2:0]         iter_q, iter_d;
    logic               ovf_q, ovf_d;
    logic               dbz_q, dbz_d;

    logic               core_load;
    logic [W-1:0]       core_dvd, core_dsr, core_quo;
    logic               core_valid;
    logic [W-1:0]       a_elem, res;
    logic               res_neg;

    scalar_div_core u_core (
        .clk        (clk),
        .rst        (rst),
        .load_i     (core_load),
        .dividend_i (core_dvd),
        .divisor_i  (core_dsr),
        .quotient_o (core_quo),
        .valid_o    (core_valid)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        idx_d     = idx_q;
        iter_d    = iter_q;
        ovf_d     = ovf_q;
        dbz_d     = dbz_q;
        core_load = 1'b0;
        // The first element is fed straight from the ports so CALC can begin on the next edge.
        core_dvd  = abs_mag(A_flat[W-1:0]);
        core_dsr  = abs_mag(scalar);
        idx_nxt   = idx_q + 1'b1;
        a_elem    = a_q[elem_lsb(idx_q) +: W];
        res_neg   = a_elem[W-1] ^ b_q[W-1];
        res       = res_neg ? (~core_quo + 1'b1) : core_quo;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d    = A_flat;
                    b_d    = scalar;
                    c_d    = '0;
                    ovf_d  = 1'b0;
                    idx_d  = '0;
                    iter_d = '0;
                    if (scalar == '0) begin
                        dbz_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        dbz_d     = 1'b0;
                        core_load = 1'b1;
                        state_d   = StCalc;
                    end
                end
            end
            StCalc: begin
                iter_d = iter_q + 3'd1;
                if (iter_q == 3'd7) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (core_valid) begin
                    c_d[elem_lsb(idx_q) +: W] = res;
                    // +128 is unrepresentable; the stored byte 8'h80 is its low 8 bits.
                    if (core_quo == 8'h80 && !res_neg) begin
                        ovf_d = 1'b1;
                    end
                    if (idx_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        idx_d     = idx_nxt;
                        iter_d    = '0;
                        core_load = 1'b1;
                        core_dvd  = abs_mag(a_q[elem_lsb(idx_nxt) +: W]);
                        core_dsr  = abs_mag(b_q);
                        state_d   = StCalc;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            idx_q   <= '0;
            iter_q  <= '0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            idx_q   <= idx_d;
            iter_q  <= iter_d;
            ovf_q   <= ovf_d;
            dbz_q   <= dbz_d;
        end
    end

    assign C_flat           = c_q;
    assign busy             = (state_q == StCalc) || (state_q == StWrite);
    assign done             = (state_q == StDone);
    assign overflow_flag    = ovf_q;
    assign div_by_zero_flag = dbz_q;

endmodule

// File: tb/tb_alu_scalar_div_module.sv
// Randomized self-checking bench for alu_scalar_div_module against a plain-arithmetic model.
module tb_alu_scalar_div_module;

    localparam int N  = 25;
    localparam int BW = 200;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [BW-1:0] A_flat = '0;
    logic [7:0]    scalar = '0;
    logic [BW-1:0] C_flat;
    logic          busy, done, overflow_flag, div_by_zero_flag;

    int n_tests = 0;
    int n_fail  = 0;

    alu_scalar_div_module dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .A_flat           (A_flat),
        .scalar           (scalar),
        .C_flat           (C_flat),
        .busy             (busy),
        .done             (done),
        .overflow_flag    (overflow_flag),
        .div_by_zero_flag (div_by_zero_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: signed integer division truncating toward zero, quotient wrapped to 8 bits.
    function automatic void model(input logic [BW-1:0] a, input logic [7:0] s,
                                  output logic [BW-1:0] c, output logic ovf, output logic dbz);
        int av, bv, q;
        c   = '0;
        ovf = 1'b0;
        dbz = (s == 8'd0);
        if (!dbz) begin
            bv = int'($signed(s));
            for (int i = 0; i < N; i++) begin
                av = int'($signed(a[i*8 +: 8]));
                q  = av / bv;
                if (q > 127) ovf = 1'b1;
                c[i*8 +: 8] = 8'(q);
            end
        end
    endfunction

    function automatic logic [BW-1:0] rand_mat();
        logic [BW-1:0] m;
        for (int i = 0; i < N; i++) m[i*8 +: 8] = 8'($urandom);
        return m;
    endfunction

    task automatic run_op(input string tag, input logic [BW-1:0] a, input logic [7:0] s,
                          input int dup_at, input int rst_at);
        logic [BW-1:0] exp_c;
        logic          exp_ovf, exp_dbz;
        int            busy_cnt, overlap, done_k;
        logic          done_after;
        model(a, s, exp_c, exp_ovf, exp_dbz);
        busy_cnt   = 0;
        overlap    = 0;
        done_k     = 0;
        done_after = 1'b1;
        @(negedge clk);
        A_flat = a;
        scalar = s;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        A_flat = rand_mat();
        scalar = 8'($urandom);
        for (int k = 1; k <= 400; k++) begin
            if (busy) busy_cnt++;
            if (busy && done) overlap++;
            if (done && done_k == 0) done_k = k;
            if (done_k != 0 && k == done_k + 1) done_after = done;
            if (rst_at != 0 && k == rst_at + 1) begin
                check({tag, "_rst_busy"}, BW'(busy), BW'(0));
                check({tag, "_rst_c"}, C_flat, '0);
                check({tag, "_rst_flags"}, BW'({overflow_flag, div_by_zero_flag}), BW'(0));
                rst = 1'b0;
            end
            start = (k == dup_at);
            if (start) begin
                A_flat = rand_mat();
                scalar = 8'($urandom_range(1, 255));
            end
            if (rst_at != 0 && k == rst_at) rst = 1'b1;
            if (rst_at == 0 && done_k != 0 && k == done_k + 1) break;
            if (rst_at != 0 && k == rst_at + 20) break;
            @(negedge clk);
        end
        start = 1'b0;
        if (rst_at != 0) begin
            check({tag, "_rst_no_done"}, BW'(done_k), BW'(0));
        end else begin
            check({tag, "_latency"}, BW'(done_k), BW'(exp_dbz ? 1 : 226));
            check({tag, "_busy_cycles"}, BW'(busy_cnt), BW'(exp_dbz ? 0 : 225));
            check({tag, "_busy_done_overlap"}, BW'(overlap), BW'(0));
            check({tag, "_done_width"}, BW'(done_after), BW'(0));
            check({tag, "_c"}, C_flat, exp_c);
            check({tag, "_ovf"}, BW'(overflow_flag), BW'(exp_ovf));
            check({tag, "_dbz"}, BW'(div_by_zero_flag), BW'(exp_dbz));
        end
    endtask

    initial begin
        logic [BW-1:0] a;
        logic [7:0]    s;
        repeat (2) @(negedge clk);
        check("reset_c", C_flat, '0);
        check("reset_ctl", BW'({busy, done, overflow_flag, div_by_zero_flag}), BW'(0));
        rst = 1'b0;

        a = '0;
        for (int i = 0; i < N; i++) a[i*8 +: 8] = 8'd100;
        run_op("all100_div7", a, 8'd7, 0, 0);

        a = '0;
        a[0*8 +: 8] = 8'h9C;
        a[1*8 +: 8] = 8'd100;
        a[2*8 +: 8] = 8'hF9;
        a[3*8 +: 8] = 8'd127;
        run_op("signs_divm7", a, 8'hF9, 0, 0);

        a = '0;
        a[0*8 +: 8] = 8'hF9;
        a[1*8 +: 8] = 8'd7;
        a[2*8 +: 8] = 8'd127;
        run_op("trunc_div2", a, 8'd2, 0, 0);
        run_op("trunc_divm128", a, 8'h80, 0, 0);

        a = '0;
        a[5*8 +: 8] = 8'h80;
        run_op("ovf_divm1", a, 8'hFF, 0, 0);
        run_op("noovf_div1", a, 8'd1, 0, 0);

        run_op("dbz", rand_mat() | BW'(1), 8'd0, 0, 0);

        s = 8'($urandom_range(1, 255));
        run_op("ignored_start", rand_mat(), s, 40, 0);
        run_op("mid_reset", rand_mat(), s, 0, 50);
        run_op("after_reset", rand_mat(), 8'hFD, 0, 0);

        for (int r = 0; r < 4; r++) begin
            case ($urandom_range(0, 5))
                0:       s = 8'd0;
                1:       s = 8'hFF;
                2:       s = 8'h80;
                default: s = 8'($urandom);
            endcase
            a = rand_mat();
            if (r == 0) a[7*8 +: 8] = 8'h80;
            run_op($sformatf("rand%0d", r), a, s, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
